// File: rtl/fpu_addsub_ctrl.sv
// Sequencing FSM for the multi-cycle FP32 add/sub datapath: special-case bypass, align/add/normalize/round strobes.
// Define FPU_FTZ_EN to flush denormal inputs and denormal results to zero.
module fpu_addsub_ctrl #(
  parameter int ALIGN_MAX = 26,
  parameter int NORM_MAX  = 24
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_add_sub,
  input  logic        i_sign_a,
  input  logic        i_sign_b,
  input  logic [7:0]  i_exp_a,
  input  logic [7:0]  i_exp_b,
  input  logic [23:0] i_man_a,
  input  logic [23:0] i_man_b,
  input  logic        i_carry,
  input  logic        i_norm_msb,
  input  logic        i_man_zero,
  input  logic        i_exp_min,
  input  logic        i_round_ovf,
  output logic        o_ld_op,
  output logic        o_align_en,
  output logic        o_add_en,
  output logic        o_norm_rshift,
  output logic        o_norm_lshift,
  output logic        o_round_en,
  output logic [1:0]  o_sel_sign,
  output logic [1:0]  o_sel_exp,
  output logic [1:0]  o_sel_man,
  output logic        o_valid,
  input  logic        i_ready
);

  localparam int AW = $clog2(ALIGN_MAX + 2);
  localparam int NW = $clog2(NORM_MAX + 2);

  localparam logic [1:0] SEL_NORM = 2'b00;
  localparam logic [1:0] SEL_ZERO = 2'b01;
  localparam logic [1:0] SEL_ONE  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_CLASSIFY, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_POSTNORM, S_DONE
  } state_t;

  state_t        r_state;
  logic [7:0]    r_expA, r_expB;
  logic [23:0]   r_manA, r_manB;
  logic          r_effSub;
  logic [AW-1:0] r_alignCnt;
  logic [NW-1:0] r_lCnt;
  logic [1:0]    r_selSign, r_selExp, r_selMan;

  logic          w_accept;
  logic          w_nanA, w_nanB, w_infA, w_infB, w_zeroA, w_zeroB;
  logic [7:0]    w_expAdjA, w_expAdjB, w_diff;
  logic [AW-1:0] w_alignLoad;
  logic          w_normFirst, w_lshiftOk, w_normCarry, w_normZero, w_normShift, w_ftzFlush;

  assign w_accept = i_valid && (r_state == S_IDLE);

  assign w_nanA = (r_expA == 8'hFF) && (r_manA[22:0] != 23'd0);
  assign w_nanB = (r_expB == 8'hFF) && (r_manB[22:0] != 23'd0);
  assign w_infA = (r_expA == 8'hFF) && (r_manA[22:0] == 23'd0);
  assign w_infB = (r_expB == 8'hFF) && (r_manB[22:0] == 23'd0);

`ifdef FPU_FTZ_EN
  assign w_zeroA    = (r_expA == 8'h00);
  assign w_zeroB    = (r_expB == 8'h00);
  assign w_ftzFlush = !i_norm_msb && i_exp_min;
`else
  assign w_zeroA    = (r_expA == 8'h00) && (r_manA == 24'd0);
  assign w_zeroB    = (r_expB == 8'h00) && (r_manB == 24'd0);
  assign w_ftzFlush = 1'b0;
`endif

  // Denormals share the exponent of the smallest normal when aligning.
  assign w_expAdjA   = (r_expA == 8'h00) ? 8'd1 : r_expA;
  assign w_expAdjB   = (r_expB == 8'h00) ? 8'd1 : r_expB;
  assign w_diff      = (w_expAdjA >= w_expAdjB) ? (w_expAdjA - w_expAdjB) : (w_expAdjB - w_expAdjA);
  assign w_alignLoad = (int'(w_diff) > ALIGN_MAX) ? AW'(ALIGN_MAX) : AW'(w_diff);

  // The first NORM cycle is recognised by a zero shift count; later cycles only run the left-shift loop.
  assign w_normFirst = (r_lCnt == '0);
  assign w_lshiftOk  = !i_norm_msb && !i_exp_min && (int'(r_lCnt) < NORM_MAX);
  assign w_normCarry = (r_state == S_NORM) && w_normFirst && i_carry;
  assign w_normZero  = (r_state == S_NORM) && w_normFirst && !i_carry && i_man_zero;
  assign w_normShift = (r_state == S_NORM) && !w_normCarry && !w_normZero && w_lshiftOk;

  assign o_ready       = (r_state == S_IDLE);
  assign o_ld_op       = w_accept;
  assign o_align_en    = (r_state == S_ALIGN);
  assign o_add_en      = (r_state == S_ADD);
  assign o_norm_rshift = w_normCarry || (r_state == S_POSTNORM);
  assign o_norm_lshift = w_normShift;
  assign o_round_en    = (r_state == S_ROUND);
  assign o_valid       = (r_state == S_DONE);
  assign o_sel_sign    = r_selSign;
  assign o_sel_exp     = r_selExp;
  assign o_sel_man     = r_selMan;

  // Select codes sit at NORM outside DONE, so paths that finish with all-NORM need not touch them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_expA     <= '0;
      r_expB     <= '0;
      r_manA     <= '0;
      r_manB     <= '0;
      r_effSub   <= 1'b0;
      r_alignCnt <= '0;
      r_lCnt     <= '0;
      r_selSign  <= SEL_NORM;
      r_selExp   <= SEL_NORM;
      r_selMan   <= SEL_NORM;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_expA   <= i_exp_a;
            r_expB   <= i_exp_b;
            r_manA   <= i_man_a;
            r_manB   <= i_man_b;
            r_effSub <= i_add_sub ^ i_sign_a ^ i_sign_b;
            r_lCnt   <= '0;
            r_state  <= S_CLASSIFY;
          end
        end
        S_CLASSIFY: begin
          if (w_nanA || w_nanB || (w_infA && w_infB && r_effSub)) begin
            r_selSign <= SEL_ZERO;
            r_selExp  <= SEL_ONE;
            r_selMan  <= SEL_ONE;
            r_state   <= S_DONE;
          end else if (w_infA || w_infB) begin
            r_selSign <= SEL_NORM;
            r_selExp  <= SEL_ONE;
            r_selMan  <= SEL_ZERO;
            r_state   <= S_DONE;
          end else if (w_zeroA && w_zeroB) begin
            r_selSign <= SEL_NORM;
            r_selExp  <= SEL_ZERO;
            r_selMan  <= SEL_ZERO;
            r_state   <= S_DONE;
          end else if (w_zeroA || w_zeroB) begin
            r_selSign <= SEL_NORM;
            r_selExp  <= SEL_NORM;
            r_selMan  <= SEL_NORM;
            r_state   <= S_DONE;
          end else begin
            r_alignCnt <= w_alignLoad;
            r_state    <= (w_alignLoad != '0) ? S_ALIGN : S_ADD;
          end
        end
        S_ALIGN: begin
          if (r_alignCnt <= AW'(1)) begin
            r_state <= S_ADD;
          end else begin
            r_alignCnt <= r_alignCnt - 1'b1;
          end
        end
        S_ADD: begin
          r_state <= S_NORM;
        end
        S_NORM: begin
          if (w_normCarry) begin
            r_state <= S_ROUND;
          end else if (w_normZero) begin
            r_selSign <= SEL_NORM;
            r_selExp  <= SEL_ZERO;
            r_selMan  <= SEL_ZERO;
            r_state   <= S_DONE;
          end else if (w_normShift) begin
            r_lCnt <= r_lCnt + 1'b1;
          end else if (w_ftzFlush) begin
            r_selSign <= SEL_NORM;
            r_selExp  <= SEL_ZERO;
            r_selMan  <= SEL_ZERO;
            r_state   <= S_DONE;
          end else begin
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_state <= i_round_ovf ? S_POSTNORM : S_DONE;
        end
        S_POSTNORM: begin
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (i_ready) begin
            r_selSign <= SEL_NORM;
            r_selExp  <= SEL_NORM;
            r_selMan  <= SEL_NORM;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_addsub_ctrl.sv
// Directed bench for fpu_addsub_ctrl; datapath status inputs come from a small behavioural stand-in.
// Honours FPU_FTZ_EN so the flush cases match whichever build is compiled.
module tb_fpu_addsub_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid, o_ready, i_add_sub, i_sign_a, i_sign_b;
  logic [7:0]  i_exp_a, i_exp_b;
  logic [23:0] i_man_a, i_man_b;
  logic        i_carry, i_norm_msb, i_man_zero, i_exp_min, i_round_ovf;
  logic        o_ld_op, o_align_en, o_add_en, o_norm_rshift, o_norm_lshift, o_round_en;
  logic [1:0]  o_sel_sign, o_sel_exp, o_sel_man;
  logic        o_valid, i_ready;
  logic [5:0]  selAll;
  logic [5:0]  strobeAll;

  int total = 0;
  int bad = 0;
  int doneCyc, alignCnt, lshCnt, rshCnt, addCnt, roundCnt, overlapCnt, msbAfter;
  logic gotValid, carryIn, manZeroIn, ovfIn, expMinIn;

  always #5 i_clk = ~i_clk;

  assign selAll    = {o_sel_sign, o_sel_exp, o_sel_man};
  assign strobeAll = {o_ld_op, o_align_en, o_add_en, o_norm_rshift, o_norm_lshift, o_round_en};

  fpu_addsub_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_add_sub(i_add_sub), .i_sign_a(i_sign_a), .i_sign_b(i_sign_b),
    .i_exp_a(i_exp_a), .i_exp_b(i_exp_b), .i_man_a(i_man_a), .i_man_b(i_man_b),
    .i_carry(i_carry), .i_norm_msb(i_norm_msb), .i_man_zero(i_man_zero),
    .i_exp_min(i_exp_min), .i_round_ovf(i_round_ovf),
    .o_ld_op(o_ld_op), .o_align_en(o_align_en), .o_add_en(o_add_en),
    .o_norm_rshift(o_norm_rshift), .o_norm_lshift(o_norm_lshift), .o_round_en(o_round_en),
    .o_sel_sign(o_sel_sign), .o_sel_exp(o_sel_exp), .o_sel_man(o_sel_man),
    .o_valid(o_valid), .i_ready(i_ready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic setDatapath(input logic carry, input logic manZero, input logic ovf,
                             input logic expMin, input int msbAft);
    carryIn   = carry;
    manZeroIn = manZero;
    ovfIn     = ovf;
    expMinIn  = expMin;
    msbAfter  = msbAft;
  endtask

  // Called at posedge+1 in IDLE; returns at posedge+1 of the CLASSIFY cycle.
  task automatic applyStimulus(input logic addSub, input logic [31:0] a, input logic [31:0] b);
    i_add_sub = addSub;
    i_sign_a  = a[31];
    i_exp_a   = a[30:23];
    i_man_a   = {(a[30:23] != 8'h00), a[22:0]};
    i_sign_b  = b[31];
    i_exp_b   = b[30:23];
    i_man_b   = {(b[30:23] != 8'h00), b[22:0]};
    i_valid   = 1'b1;
    @(negedge i_clk);
    checkOutput("ready_at_accept", 32'(o_ready), 32'd1);
    checkOutput("ld_op_at_accept", 32'(o_ld_op), 32'd1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  // Steps the datapath stand-in until o_valid, leaving time at the negedge of the first DONE cycle.
  task automatic runOp();
    int cyc;
    cyc = 1;
    alignCnt = 0; lshCnt = 0; rshCnt = 0; addCnt = 0; roundCnt = 0; overlapCnt = 0;
    gotValid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      i_carry     = carryIn;
      i_man_zero  = manZeroIn;
      i_round_ovf = ovfIn;
      i_exp_min   = expMinIn;
      i_norm_msb  = (lshCnt >= msbAfter);
      @(negedge i_clk);
      if (o_valid === 1'b1) begin
        gotValid = 1'b1;
        break;
      end
      alignCnt += int'(o_align_en);
      addCnt   += int'(o_add_en);
      rshCnt   += int'(o_norm_rshift);
      lshCnt   += int'(o_norm_lshift);
      roundCnt += int'(o_round_en);
      if ($countones(strobeAll) > 1) overlapCnt++;
      @(posedge i_clk);
      #1;
      cyc++;
    end
    doneCyc = cyc;
    checkOutput("valid_within_budget", 32'(gotValid), 32'd1);
  endtask

  task automatic endOp();
    @(posedge i_clk);
    #1;
    checkOutput("idle_ready", 32'(o_ready), 32'd1);
    checkOutput("idle_valid", 32'(o_valid), 32'd0);
    checkOutput("idle_sel", 32'(selAll), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int validSeen;
    logic [5:0] heldSel;
    i_rst_n = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_add_sub = 1'b0;
    i_sign_a = 1'b0; i_sign_b = 1'b0; i_exp_a = '0; i_exp_b = '0; i_man_a = '0; i_man_b = '0;
    i_carry = 1'b0; i_norm_msb = 1'b1; i_man_zero = 1'b0; i_exp_min = 1'b0; i_round_ovf = 1'b0;
    setDatapath(1'b0, 1'b0, 1'b0, 1'b0, 0);
    #1 i_rst_n = 1'b0;
    #1;
    checkOutput("rst_ready", 32'(o_ready), 32'd1);
    checkOutput("rst_valid", 32'(o_valid), 32'd0);
    checkOutput("rst_strobes", 32'(strobeAll), 32'd0);
    checkOutput("rst_sel", 32'(selAll), 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    $display("[TB] NaN operand");
    applyStimulus(1'b0, 32'h7FC00000, 32'h3F800000);
    runOp();
    checkOutput("nan_cycle", doneCyc, 32'd2);
    checkOutput("nan_sel", 32'(selAll), 32'(6'b01_10_10));
    endOp();

    $display("[TB] +Inf - +Inf");
    applyStimulus(1'b1, 32'h7F800000, 32'h7F800000);
    runOp();
    checkOutput("infsub_cycle", doneCyc, 32'd2);
    checkOutput("infsub_sel", 32'(selAll), 32'(6'b01_10_10));
    endOp();

    $display("[TB] +Inf + 1.0");
    applyStimulus(1'b0, 32'h7F800000, 32'h3F800000);
    runOp();
    checkOutput("inf_cycle", doneCyc, 32'd2);
    checkOutput("inf_sel", 32'(selAll), 32'(6'b00_10_01));
    endOp();

    $display("[TB] zero cases");
    applyStimulus(1'b0, 32'h00000000, 32'h80000000);
    runOp();
    checkOutput("zz_cycle", doneCyc, 32'd2);
    checkOutput("zz_sel", 32'(selAll), 32'(6'b00_01_01));
    endOp();
    applyStimulus(1'b0, 32'h00000000, 32'h3F800000);
    runOp();
    checkOutput("z1_cycle", doneCyc, 32'd2);
    checkOutput("z1_sel", 32'(selAll), 32'd0);
    endOp();

    $display("[TB] align cap, diff 40");
    applyStimulus(1'b0, 32'h3F800000, 32'h2B800000);
    runOp();
    checkOutput("cap_align", alignCnt, 32'd26);
    checkOutput("cap_add", addCnt, 32'd1);
    checkOutput("cap_round", roundCnt, 32'd1);
    checkOutput("cap_cycle", doneCyc, 32'd31);
    checkOutput("cap_overlap", overlapCnt, 32'd0);
    endOp();

    $display("[TB] align diff 3");
    applyStimulus(1'b0, 32'h3E000000, 32'h3F800000);
    runOp();
    checkOutput("d3_align", alignCnt, 32'd3);
    checkOutput("d3_cycle", doneCyc, 32'd8);
    endOp();

    $display("[TB] carry right shift");
    setDatapath(1'b1, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 32'h3FC00000, 32'h3FC00000);
    runOp();
    checkOutput("carry_rsh", rshCnt, 32'd1);
    checkOutput("carry_lsh", lshCnt, 32'd0);
    checkOutput("carry_cycle", doneCyc, 32'd5);
    endOp();

    $display("[TB] left normalize by 4");
    setDatapath(1'b0, 1'b0, 1'b0, 1'b0, 4);
    applyStimulus(1'b1, 32'h3F800000, 32'h3F700000);
    runOp();
    checkOutput("lsh_align", alignCnt, 32'd1);
    checkOutput("lsh_count", lshCnt, 32'd4);
    checkOutput("lsh_rsh", rshCnt, 32'd0);
    checkOutput("lsh_cycle", doneCyc, 32'd10);
    checkOutput("lsh_sel", 32'(selAll), 32'd0);
    checkOutput("lsh_overlap", overlapCnt, 32'd0);
    endOp();

    $display("[TB] exact cancellation");
    setDatapath(1'b0, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 32'h3F800000, 32'h3F800000);
    runOp();
    checkOutput("cancel_cycle", doneCyc, 32'd4);
    checkOutput("cancel_sel", 32'(selAll), 32'(6'b00_01_01));
    endOp();

    $display("[TB] round overflow");
    setDatapath(1'b0, 1'b0, 1'b1, 1'b0, 0);
    applyStimulus(1'b0, 32'h3F800000, 32'h3F800000);
    runOp();
    checkOutput("ovf_rsh", rshCnt, 32'd1);
    checkOutput("ovf_round", roundCnt, 32'd1);
    checkOutput("ovf_cycle", doneCyc, 32'd6);
    endOp();

    $display("[TB] exponent floor stops normalize");
    setDatapath(1'b0, 1'b0, 1'b0, 1'b1, 100);
    applyStimulus(1'b1, 32'h3F800000, 32'h3F800000);
    runOp();
    checkOutput("emin_lsh", lshCnt, 32'd0);
`ifdef FPU_FTZ_EN
    checkOutput("emin_cycle", doneCyc, 32'd4);
    checkOutput("emin_sel", 32'(selAll), 32'(6'b00_01_01));
`else
    checkOutput("emin_cycle", doneCyc, 32'd5);
    checkOutput("emin_sel", 32'(selAll), 32'd0);
`endif
    endOp();

    $display("[TB] denormal plus zero");
    setDatapath(1'b0, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 32'h00000001, 32'h00000000);
    runOp();
    checkOutput("denorm_cycle", doneCyc, 32'd2);
`ifdef FPU_FTZ_EN
    checkOutput("denorm_sel", 32'(selAll), 32'(6'b00_01_01));
`else
    checkOutput("denorm_sel", 32'(selAll), 32'd0);
`endif
    endOp();

    $display("[TB] backpressure in DONE");
    i_ready = 1'b0;
    applyStimulus(1'b0, 32'h7F800000, 32'h3F800000);
    runOp();
    checkOutput("bp_cycle", doneCyc, 32'd2);
    heldSel = 6'b00_10_01;
    for (int k = 0; k < 10; k++) begin
      @(posedge i_clk); #1;
      i_valid = 1'b1;
      i_exp_a = 8'hFF;
      i_man_a = 24'hC00000;
      @(negedge i_clk);
      checkOutput("bp_valid", 32'(o_valid), 32'd1);
      checkOutput("bp_ready", 32'(o_ready), 32'd0);
      checkOutput("bp_ld_op", 32'(o_ld_op), 32'd0);
      checkOutput("bp_sel", 32'(selAll), 32'(heldSel));
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    endOp();

    $display("[TB] reset during ALIGN");
    applyStimulus(1'b0, 32'h3F800000, 32'h2B800000);
    repeat (3) begin
      @(posedge i_clk); #1;
    end
    @(negedge i_clk);
    checkOutput("mid_align_en", 32'(o_align_en), 32'd1);
    #1 i_rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ready", 32'(o_ready), 32'd1);
    checkOutput("mid_rst_valid", 32'(o_valid), 32'd0);
    checkOutput("mid_rst_strobes", 32'(strobeAll), 32'd0);
    checkOutput("mid_rst_sel", 32'(selAll), 32'd0);
    @(posedge i_clk); #1;
    checkOutput("mid_rst_hold_ready", 32'(o_ready), 32'd1);
    i_rst_n = 1'b1;
    validSeen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      if (o_valid !== 1'b0) validSeen++;
    end
    checkOutput("mid_rst_no_valid", validSeen, 32'd0);
    checkOutput("mid_rst_idle", 32'(o_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
